lfsr_ctrl: RTL and testbench

Sequencing controller for a maximal-length Fibonacci LFSR of width N (2..8). The controller accepts a seed and a mode on a start pulse, loads an internal LFSR core, and then does one of two things. In measure mode it steps the core until the state returns to the seed and reports the period and a pass flag. In stream mode it emits a requested number of LFSR words over a valid/ready handshake. It sits between test/config logic and the LFSR datapath, and is the only agent that drives the core's load and step controls.

---
 rtl/lfsr_pkg.sv | 31 +++
 rtl/lfsr_core.sv | 34 +++
 rtl/lfsr_ctrl.sv | 150 +++++++++++++++
 tb/tb_lfsr_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types, mode encodings and feedback-tap function for the LFSR controller.
package lfsr_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_MEASURE,
      S_STREAM,
      S_FINISH
   } state_e;

   localparam logic MODE_MEASURE = 1'b0;
   localparam logic MODE_STREAM  = 1'b1;

   // Feedback bit for a maximal-length Fibonacci LFSR of width n; s is zero-extended state.
   function automatic logic tap_fb(input int n, input logic [7:0] s);
      logic fb;
      case (n)
         2:       fb = s[1] ^ s[0];
         3:       fb = s[2] ^ s[1];
         4:       fb = s[3] ^ s[2];
         5:       fb = s[4] ^ s[2];
         6:       fb = s[5] ^ s[4];
         7:       fb = s[6] ^ s[5];
         8:       fb = s[7] ^ s[5] ^ s[4] ^ s[3];
         default: fb = 1'b0;
      endcase
      return fb;
   endfunction

endpackage

// File: rtl/lfsr_core.sv
// LFSR datapath: load has priority over step; state resets to all ones.
module lfsr_core
   import lfsr_pkg::*;
#(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         load_i,
   input  logic         step_i,
   input  logic [N-1:0] seed_i,
   output logic [N-1:0] state_o,
   output logic [N-1:0] next_state_o
);

   logic [N-1:0] state_q, state_d;
   logic [7:0]   state_ext;

   assign state_ext    = 8'(state_q);
   assign next_state_o = {state_q[N-2:0], tap_fb(N, state_ext)};
   assign state_o      = state_q;

   always_comb begin
      state_d = state_q;
      if (load_i)      state_d = seed_i;
      else if (step_i) state_d = next_state_o;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= '1;
      else          state_q <= state_d;
   end

endmodule

// File: rtl/lfsr_ctrl.sv
// Sequencer for an LFSR core: measures the period from a seed, or streams words over valid/ready.
//   state   | meaning
//   IDLE    | waiting for start; latches seed/mode/count
//   LOAD    | core loads latched seed; results cleared
//   MEASURE | core steps each cycle until it returns to the seed or times out
//   STREAM  | presents core state as a word; steps on each handshake
//   FINISH  | one-cycle done pulse
module lfsr_ctrl
   import lfsr_pkg::*;
#(
   parameter int N     = 4,
   parameter int CNT_W = N + 1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start_i,
   input  logic             mode_i,
   input  logic [N-1:0]     seed_i,
   input  logic [CNT_W-1:0] count_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [CNT_W-1:0] period_o,
   output logic             pass_o,
   output logic             err_zero_o,
   output logic [N-1:0]     word_data_o,
   output logic             word_valid_o,
   input  logic             word_ready_i
);

   localparam logic [CNT_W-1:0] FULL   = CNT_W'(2**N);
   localparam logic [CNT_W-1:0] MAXLEN = CNT_W'(2**N - 1);

   state_e           state_q, state_d;
   logic             mode_q, mode_d;
   logic [N-1:0]     seed_q, seed_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] rem_q, rem_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             pass_q, pass_d;
   logic             err_zero_q, err_zero_d;
   logic [CNT_W-1:0] cnt_inc;
   logic             core_load, core_step;
   logic [N-1:0]     core_state, core_next;

   lfsr_core #(.N(N)) u_core (
      .clk          (clk),
      .reset_n      (reset_n),
      .load_i       (core_load),
      .step_i       (core_step),
      .seed_i       (seed_q),
      .state_o      (core_state),
      .next_state_o (core_next)
   );

   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      seed_d     = seed_q;
      cnt_d      = cnt_q;
      rem_d      = rem_q;
      period_d   = period_q;
      pass_d     = pass_q;
      err_zero_d = err_zero_q;
      core_load  = 1'b0;
      core_step  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               mode_d = mode_i;
               seed_d = seed_i;
               rem_d  = count_i;
               if (seed_i == '0) begin
                  err_zero_d = 1'b1;
                  period_d   = '0;
                  pass_d     = 1'b0;
                  state_d    = S_FINISH;
               end else begin
                  state_d = S_LOAD;
               end
            end
         end
         S_LOAD: begin
            core_load  = 1'b1;
            period_d   = '0;
            pass_d     = 1'b0;
            err_zero_d = 1'b0;
            cnt_d      = '0;
            if (mode_q == MODE_MEASURE) state_d = S_MEASURE;
            else if (rem_q == '0)       state_d = S_FINISH;
            else                        state_d = S_STREAM;
         end
         S_MEASURE: begin
            core_step = 1'b1;
            cnt_d     = cnt_inc;
            // Match is checked on the post-step state, so the period is the step count.
            if (core_next == seed_q) begin
               period_d = cnt_inc;
               pass_d   = (cnt_inc == MAXLEN);
               state_d  = S_FINISH;
            end else if (cnt_inc == FULL) begin
               period_d = '0;
               pass_d   = 1'b0;
               state_d  = S_FINISH;
            end
         end
         S_STREAM: begin
            if (word_ready_i) begin
               core_step = 1'b1;
               rem_d     = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) state_d = S_FINISH;
            end
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_IDLE;
         mode_q     <= MODE_MEASURE;
         seed_q     <= '0;
         cnt_q      <= '0;
         rem_q      <= '0;
         period_q   <= '0;
         pass_q     <= 1'b0;
         err_zero_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         seed_q     <= seed_d;
         cnt_q      <= cnt_d;
         rem_q      <= rem_d;
         period_q   <= period_d;
         pass_q     <= pass_d;
         err_zero_q <= err_zero_d;
      end
   end

   assign busy_o       = (state_q != S_IDLE);
   assign done_o       = (state_q == S_FINISH);
   assign word_valid_o = (state_q == S_STREAM);
   assign word_data_o  = word_valid_o ? core_state : '0;
   assign period_o     = period_q;
   assign pass_o       = pass_q;
   assign err_zero_o   = err_zero_q;

endmodule

// File: tb/tb_lfsr_ctrl.sv
// Directed bench for lfsr_ctrl: N=4 and N=8 instances, hand-computed expectations.
module tb_lfsr_ctrl;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;

   logic       start4 = 1'b0, mode4 = 1'b0, ready4 = 1'b0;
   logic [3:0] seed4 = '0;
   logic [4:0] count4 = '0;
   logic       busy4, done4, pass4, errz4, wvalid4;
   logic [4:0] period4;
   logic [3:0] wdata4;

   logic       start8 = 1'b0, mode8 = 1'b0, ready8 = 1'b0;
   logic [7:0] seed8 = '0;
   logic [8:0] count8 = '0;
   logic       busy8, done8, pass8, errz8, wvalid8;
   logic [8:0] period8;
   logic [7:0] wdata8;

   int ntests = 0;
   int nfail  = 0;
   int cyc, dcyc, k, last_hs;
   bit saw_valid;
   logic [3:0] exp_words [4];
   logic [3:0] meas_states [5];

   always #5 clk = ~clk;

   lfsr_ctrl #(.N(4)) dut4 (
      .clk(clk), .reset_n(reset_n), .start_i(start4), .mode_i(mode4), .seed_i(seed4),
      .count_i(count4), .busy_o(busy4), .done_o(done4), .period_o(period4), .pass_o(pass4),
      .err_zero_o(errz4), .word_data_o(wdata4), .word_valid_o(wvalid4), .word_ready_i(ready4)
   );

   lfsr_ctrl #(.N(8)) dut8 (
      .clk(clk), .reset_n(reset_n), .start_i(start8), .mode_i(mode8), .seed_i(seed8),
      .count_i(count8), .busy_o(busy8), .done_o(done8), .period_o(period8), .pass_o(pass8),
      .err_zero_o(errz8), .word_data_o(wdata8), .word_valid_o(wvalid8), .word_ready_i(ready8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   // Start is sampled on the edge that ends cycle 0; returns 1 ns into cycle 1.
   task automatic go4(input logic m, input logic [3:0] s, input logic [4:0] c);
      mode4  = m;
      seed4  = s;
      count4 = c;
      start4 = 1'b1;
      @(posedge clk);
      #1;
      start4 = 1'b0;
      cyc    = 1;
   endtask

   initial begin
      exp_words   = '{4'h1, 4'h2, 4'h4, 4'h9};
      meas_states = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3};

      @(negedge clk);
      chk("rst_busy",   32'(busy4),   32'd0);
      chk("rst_done",   32'(done4),   32'd0);
      chk("rst_period", 32'(period4), 32'd0);
      chk("rst_pass",   32'(pass4),   32'd0);
      chk("rst_errz",   32'(errz4),   32'd0);
      chk("rst_wdata",  32'(wdata4),  32'd0);
      chk("rst_wvalid", 32'(wvalid4), 32'd0);
      chk("rst_core",   32'(dut4.u_core.state_o), 32'hF);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      next_cyc();

      // zero seed
      go4(1'b0, 4'h0, 5'd0);
      @(negedge clk);
      chk("zero_done_c1", 32'(done4),  32'd1);
      chk("zero_busy_c1", 32'(busy4),  32'd1);
      chk("zero_errz",    32'(errz4),  32'd1);
      chk("zero_period",  32'(period4), 32'd0);
      chk("zero_pass",    32'(pass4),  32'd0);
      chk("zero_core_c1", 32'(dut4.u_core.state_o), 32'hF);
      next_cyc();
      @(negedge clk);
      chk("zero_busy_c2", 32'(busy4), 32'd0);
      chk("zero_done_c2", 32'(done4), 32'd0);
      chk("zero_errz_hold", 32'(errz4), 32'd1);
      chk("zero_core_c2", 32'(dut4.u_core.state_o), 32'hF);
      next_cyc();

      // measure, seed 0001, stray start at cycle 5
      go4(1'b0, 4'h1, 5'd0);
      dcyc = 0;
      while (dcyc == 0 && cyc < 40) begin
         @(negedge clk);
         if (cyc >= 2 && cyc <= 6) chk("meas_core", 32'(dut4.u_core.state_o), 32'(meas_states[cyc-2]));
         if (done4) dcyc = cyc;
         else begin
            next_cyc();
            start4 = (cyc == 5);
         end
      end
      start4 = 1'b0;
      chk("meas_done_cyc", dcyc, 32'd17);
      chk("meas_period",   32'(period4), 32'd15);
      chk("meas_pass",     32'(pass4),   32'd1);
      chk("meas_errz",     32'(errz4),   32'd0);
      next_cyc();
      @(negedge clk);
      chk("meas_idle_busy",   32'(busy4),   32'd0);
      chk("meas_period_hold", 32'(period4), 32'd15);
      next_cyc();

      // stream 4 words, ready low cycles 2..4
      ready4 = 1'b0;
      go4(1'b1, 4'h1, 5'd4);
      k = 0; last_hs = 0; dcyc = 0;
      while (dcyc == 0 && cyc < 40) begin
         @(negedge clk);
         if (cyc == 1) chk("strm_valid_c1", 32'(wvalid4), 32'd0);
         if (cyc >= 2 && cyc <= 4) begin
            chk("strm_stall_valid", 32'(wvalid4), 32'd1);
            chk("strm_stall_data",  32'(wdata4),  32'h1);
         end
         if (wvalid4 && ready4) begin
            if (k < 4) chk("strm_word", 32'(wdata4), 32'(exp_words[k]));
            k++;
            last_hs = cyc;
         end
         if (done4) dcyc = cyc;
         else begin
            next_cyc();
            ready4 = (cyc >= 5);
         end
      end
      chk("strm_done_cyc", dcyc,    32'd9);
      chk("strm_nwords",   k,       32'd4);
      chk("strm_last_hs",  last_hs, 32'd8);
      chk("strm_valid_fin", 32'(wvalid4), 32'd0);
      chk("strm_period",   32'(period4), 32'd0);
      ready4 = 1'b0;
      next_cyc();
      next_cyc();

      // stream with count 0
      ready4 = 1'b1;
      go4(1'b1, 4'h1, 5'd0);
      saw_valid = 1'b0; dcyc = 0;
      while (dcyc == 0 && cyc < 20) begin
         @(negedge clk);
         if (wvalid4) saw_valid = 1'b1;
         if (done4) dcyc = cyc;
         else next_cyc();
      end
      chk("cnt0_done_cyc", dcyc, 32'd2);
      chk("cnt0_no_valid", 32'(saw_valid), 32'd0);
      ready4 = 1'b0;
      next_cyc();
      next_cyc();

      // reset at cycle 8 of a measure run
      go4(1'b0, 4'h1, 5'd0);
      while (cyc < 8) next_cyc();
      reset_n = 1'b0;
      #1;
      chk("abort_busy",   32'(busy4),   32'd0);
      chk("abort_done",   32'(done4),   32'd0);
      chk("abort_period", 32'(period4), 32'd0);
      chk("abort_pass",   32'(pass4),   32'd0);
      chk("abort_wvalid", 32'(wvalid4), 32'd0);
      chk("abort_core",   32'(dut4.u_core.state_o), 32'hF);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("abort_no_done", 32'(done4), 32'd0);
         next_cyc();
      end
      reset_n = 1'b1;
      next_cyc();
      go4(1'b0, 4'h1, 5'd0);
      dcyc = 0;
      while (dcyc == 0 && cyc < 40) begin
         @(negedge clk);
         if (done4) dcyc = cyc;
         else next_cyc();
      end
      chk("rerun_done_cyc", dcyc, 32'd17);
      chk("rerun_period",   32'(period4), 32'd15);
      chk("rerun_pass",     32'(pass4),   32'd1);
      next_cyc();

      // N=8 measure, seed FF
      mode8  = 1'b0;
      seed8  = 8'hFF;
      count8 = '0;
      start8 = 1'b1;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      cyc    = 1;
      dcyc   = 0;
      while (dcyc == 0 && cyc < 300) begin
         @(negedge clk);
         if (done8) dcyc = cyc;
         else next_cyc();
      end
      chk("n8_done_cyc", dcyc, 32'd257);
      chk("n8_period",   32'(period8), 32'd255);
      chk("n8_pass",     32'(pass8),   32'd1);
      chk("n8_errz",     32'(errz8),   32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
